mod_updown_counter: RTL and testbench

- Parametrised successor of the team's 3-bit synchronous up/down counter.
- Adds: generic width, programmable modulus, parallel load, wrap/saturate mode, registered carry/borrow pulses and a combinational terminal-count flag.
- Used as a general event/timer counter and cascadable via tc into a higher-order stage's count input.

---
 rtl/mod_updown_counter.sv | 115 +++++++++++
 tb/tb_mod_updown_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
// Parametrised modulo-MODULUS up/down counter with parallel load,
// wrap/saturate mode, registered carry/borrow pulses and a combinational
// terminal-count flag for cascading.
//
// Ports:
//   clk    in          rising-edge clock
//   reset  in          asynchronous, active-high reset (q, cout, bout -> 0)
//   count  in          count enable
//   dir    in          1 = up, 0 = down
//   load   in          synchronous parallel load, wins over count
//   din    in  WIDTH   load value, clamped to MODULUS-1
//   sat    in          0 = wrap at range ends, 1 = saturate
//   q      out WIDTH   registered count value
//   cout   out         one-cycle carry pulse, present with the wrapped q
//   bout   out         one-cycle borrow pulse, present with the wrapped q
//   tc     out         terminal count, high in the cycle before a wrap
//
// Handshake: there is no valid/ready pair. count is a pure per-edge
// qualifier sampled on every rising edge; outputs are valid every cycle.
// There is no FSM: the only state is q plus the two pulse flops.
module mod_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             bout,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             bout_q, bout_d;

  logic             q_over_max;
  logic             din_over_max;
  logic [WIDTH-1:0] din_clamped;

  // When MODULUS fills the whole WIDTH range no value can exceed MAX,
  // so the range compares collapse to constants instead of being
  // always-false comparisons.
  generate
    if (MODULUS < (1 << WIDTH)) begin : g_partial_range
      assign q_over_max   = (q_q > MAX_V);
      assign din_over_max = (din > MAX_V);
    end else begin : g_full_range
      assign q_over_max   = 1'b0;
      assign din_over_max = 1'b0;
    end
  endgenerate

  assign din_clamped = din_over_max ? MAX_V : din;

  always_comb begin
    q_d    = q_q;
    cout_d = 1'b0;
    bout_d = 1'b0;
    if (load) begin
      q_d = din_clamped;
    end else if (count) begin
      if (q_over_max) begin
        // Recovery from a state outside 0..MAX, either direction.
        q_d = '0;
      end else if (dir) begin
        if (q_q == MAX_V) begin
          if (!sat) begin
            q_d    = '0;
            cout_d = 1'b1;
          end
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          if (!sat) begin
            q_d    = MAX_V;
            bout_d = 1'b1;
          end
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      cout_q <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
      bout_q <= bout_d;
    end
  end

  assign q    = q_q;
  assign cout = cout_q;
  assign bout = bout_q;
  // Deliberately ignores sat and load so a cascaded stage sees the same
  // terminal-count timing regardless of mode.
  assign tc   = count & ((dir & (q_q == MAX_V)) | (~dir & (q_q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter
// Directed bench for mod_updown_counter. Three targets share one clock:
//   sel 0: default instance (WIDTH=3, MODULUS=8)
//   sel 1: MODULUS=6 instance
//   sel 2: two MODULUS=8 stages cascaded via tc; q field is {hi,lo},
//          cout field is the high-stage carry, bout field the low-stage carry.
// The driver sets inputs just after a rising edge and pushes the values
// expected at the following falling edge; the monitor pops and compares.
module tb_mod_updown_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       a_rst = 1'b1, a_count = 1'b0, a_dir = 1'b0, a_load = 1'b0, a_sat = 1'b0;
  logic [2:0] a_din = '0;
  logic [2:0] a_q;
  logic       a_cout, a_bout, a_tc;

  logic       b_rst = 1'b1, b_count = 1'b0, b_dir = 1'b0, b_load = 1'b0, b_sat = 1'b0;
  logic [2:0] b_din = '0;
  logic [2:0] b_q;
  logic       b_cout, b_bout, b_tc;

  logic       c_rst = 1'b1, c_count = 1'b0;
  logic [2:0] lo_q, hi_q;
  logic       lo_cout, lo_bout, lo_tc, hi_cout, hi_bout, hi_tc;

  mod_updown_counter dut_a (
    .clk(clk), .reset(a_rst), .count(a_count), .dir(a_dir), .load(a_load),
    .din(a_din), .sat(a_sat), .q(a_q), .cout(a_cout), .bout(a_bout), .tc(a_tc)
  );

  mod_updown_counter #(.WIDTH(3), .MODULUS(6)) dut_b (
    .clk(clk), .reset(b_rst), .count(b_count), .dir(b_dir), .load(b_load),
    .din(b_din), .sat(b_sat), .q(b_q), .cout(b_cout), .bout(b_bout), .tc(b_tc)
  );

  mod_updown_counter #(.WIDTH(3), .MODULUS(8)) dut_lo (
    .clk(clk), .reset(c_rst), .count(c_count), .dir(1'b1), .load(1'b0),
    .din(3'd0), .sat(1'b0), .q(lo_q), .cout(lo_cout), .bout(lo_bout), .tc(lo_tc)
  );

  mod_updown_counter #(.WIDTH(3), .MODULUS(8)) dut_hi (
    .clk(clk), .reset(c_rst), .count(lo_tc), .dir(1'b1), .load(1'b0),
    .din(3'd0), .sat(1'b0), .q(hi_q), .cout(hi_cout), .bout(hi_bout), .tc(hi_tc)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] q;
    logic       cout;
    logic       bout;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Hand-computed vectors for the directed sequences.
  logic [2:0] up8_q   [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       up8_co  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       up8_tc  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] dn6_q   [7]  = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic       dn6_bo  [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       dn6_tc  [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] satu_q  [5]  = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
  logic       satu_tc [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0] satd_q  [4]  = '{3'd1, 3'd0, 3'd0, 3'd0};
  logic       satd_tc [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic ld, input logic [2:0] d, input logic cnt,
                       input logic dr, input logic st);
    a_load = ld; a_din = d; a_count = cnt; a_dir = dr; a_sat = st;
  endtask

  task automatic set_b(input logic ld, input logic [2:0] d, input logic cnt,
                       input logic dr, input logic st);
    b_load = ld; b_din = d; b_count = cnt; b_dir = dr; b_sat = st;
  endtask

  task automatic push(input int sel, input logic [7:0] qv, input logic co,
                      input logic bo, input logic t);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.q = qv; e.cout = co; e.bout = bo; e.tc = t;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t       e;
      logic [7:0] aq;
      logic       ac, ab, at;
      string      nm;
      e = exp_q.pop_front();
      case (e.sel)
        0: begin aq = {5'd0, a_q}; ac = a_cout; ab = a_bout; at = a_tc; nm = "mod8"; end
        1: begin aq = {5'd0, b_q}; ac = b_cout; ab = b_bout; at = b_tc; nm = "mod6"; end
        default: begin
          aq = {2'd0, hi_q, lo_q}; ac = hi_cout; ab = lo_cout; at = lo_tc; nm = "cascade";
        end
      endcase
      n_cmp++;
      if (e.cyc != cyc || aq !== e.q || ac !== e.cout || ab !== e.bout || at !== e.tc) begin
        n_err++;
        $display("FAIL %s cyc=%0d (due %0d): got q=%0d cout=%0b bout=%0b tc=%0b, want q=%0d cout=%0b bout=%0b tc=%0b",
                 nm, cyc, e.cyc, aq, ac, ab, at, e.q, e.cout, e.bout, e.tc);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two cycles, including with count/dir active.
    tick();
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_a(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // MODULUS=8 count up with wrap.
    a_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(0, {5'd0, up8_q[i]}, up8_co[i], 1'b0, up8_tc[i]);
      tick();
    end
    set_a(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    push(0, 8'd2, 1'b0, 1'b0, 1'b0);
    tick();

    // MODULUS=6 count down with wrap.
    b_rst = 1'b0;
    push(1, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_b(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      push(1, {5'd0, dn6_q[i]}, 1'b0, dn6_bo[i], dn6_tc[i]);
      tick();
    end
    set_b(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    push(1, 8'd5, 1'b0, 1'b1, 1'b0);
    tick();

    // Saturate up from 3, then saturate down from 1.
    set_b(1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
    push(1, 8'd5, 1'b0, 1'b0, 1'b1);
    tick();
    set_b(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(1, {5'd0, satu_q[i]}, 1'b0, 1'b0, satu_tc[i]);
      tick();
    end
    set_b(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    push(1, 8'd5, 1'b0, 1'b0, 1'b0);
    tick();
    set_b(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push(1, {5'd0, satd_q[i]}, 1'b0, 1'b0, satd_tc[i]);
      tick();
    end

    // Load priority, clamping, hold, and load suppressing a pulse.
    set_b(1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
    push(1, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_b(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
    push(1, 8'd4, 1'b0, 1'b0, 1'b0);
    tick();
    set_b(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    push(1, 8'd5, 1'b0, 1'b0, 1'b0);
    tick();
    set_b(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    push(1, 8'd5, 1'b0, 1'b0, 1'b1);
    tick();
    set_b(1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
    push(1, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_b(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    push(1, 8'd2, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset between edges on the MODULUS=8 instance.
    set_a(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i < 5; i++) begin
      push(0, 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_a(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    push(0, 8'd5, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    a_rst = 1'b1;
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_a(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    a_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(0, 8'(i), 1'b0, 1'b0, (i == 7));
      tick();
    end
    // A wrap just happened (cout high); reset mid-cycle must drop it.
    #2;
    a_rst = 1'b1;
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_a(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    a_rst = 1'b0;
    push(0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Cascade: combined {hi,lo} walks 0..63 and wraps to 0.
    c_rst   = 1'b0;
    c_count = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      push(2, 8'(i % 64), (i == 64), (i > 0 && (i % 8) == 0), ((i % 8) == 7));
      tick();
    end
    c_count = 1'b0;

    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
